// File: rtl/imem_boot_loader.sv
// ============================================================================
// Module   : imem_boot_loader
// Purpose  : Boot-time loader turning a header-prefixed byte stream into
//            consecutive 32-bit instruction memory writes while stalling the
//            core. Optional trailing XOR checksum: IMEM_BOOT_LOADER_CHKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_boot_loader #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter bit          BOOT_SKIP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] wr_addr0,
  output logic [31:0] wr_din0,
  output logic        we0,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    , S_CHK = 3'd7
`endif
  } state_t;

`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
  localparam state_t S_END = S_CHK;
`else
  localparam state_t S_END = S_DONE;
`endif
  localparam state_t S_RESET = BOOT_SKIP ? S_DONE : S_IDLE;

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [15:0] hdr_count;
  logic        xfer;

  assign xfer      = in_valid & in_ready;
  assign hdr_count = {in_data, count_q[7:0]};

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: in_ready = 1'b1;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
      S_CHK:                  in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign we0       = (state_q == S_WRITE);
  assign core_hold = (state_q != S_DONE);
  assign load_done = (state_q == S_DONE);
  assign load_err  = (state_q == S_ERR);
  assign wr_addr0  = addr_q;
  assign wr_din0   = din_q;

`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
  logic [7:0] chk_q, chk_d;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    din_d      = din_q;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    chk_d      = chk_q;
    if (xfer && state_q != S_CHK) chk_d = chk_q ^ in_data;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_req) begin
          state_d    = S_HDR0;
          word_cnt_d = 16'd0;
          byte_cnt_d = 2'd0;
          addr_d     = BASE_ADDR;
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
          chk_d      = 8'd0;
`endif
        end
      end
      S_HDR0: begin
        if (xfer) begin
          count_d[7:0] = in_data;
          state_d      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          count_d = hdr_count;
          if ({16'd0, hdr_count} > 32'(DEPTH)) state_d = S_ERR;
          else if (hdr_count == 16'd0)         state_d = S_END;
          else                                 state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          // Shift right so the first byte of the word lands in [7:0].
          if (byte_cnt_q == 2'd3) begin
            din_d   = {in_data, shift_q};
            state_d = S_WRITE;
          end else begin
            shift_d = {in_data, shift_q[23:8]};
          end
        end
      end
      S_WRITE: begin
        addr_d     = addr_q + 32'd4;
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = (word_cnt_q + 16'd1 == count_q) ? S_END : S_DATA;
      end
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (in_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESET;
      count_q    <= 16'd0;
      word_cnt_q <= 16'd0;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'd0;
      addr_q     <= BASE_ADDR;
      din_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
    end
  end

`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) chk_q <= 8'd0;
    else     chk_q <= chk_d;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
// ============================================================================
// Module   : tb_imem_boot_loader
// Purpose  : Directed self-checking bench for imem_boot_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_req;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] wr_addr0;
  logic [31:0] wr_din0;
  logic        we0;
  logic        core_hold;
  logic        load_done;
  logic        load_err;

  logic        sk_in_ready;
  logic [31:0] sk_wr_addr0;
  logic [31:0] sk_wr_din0;
  logic        sk_we0;
  logic        sk_core_hold;
  logic        sk_load_done;
  logic        sk_load_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  always #5 clk = ~clk;

  imem_boot_loader u_dut (
    .clk       (clk),
    .rst       (rst),
    .load_req  (load_req),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_addr0  (wr_addr0),
    .wr_din0   (wr_din0),
    .we0       (we0),
    .core_hold (core_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  imem_boot_loader #(.BOOT_SKIP(1'b1)) u_skip (
    .clk       (clk),
    .rst       (rst),
    .load_req  (1'b0),
    .in_data   (8'h00),
    .in_valid  (1'b0),
    .in_ready  (sk_in_ready),
    .wr_addr0  (sk_wr_addr0),
    .wr_din0   (sk_wr_din0),
    .we0       (sk_we0),
    .core_hold (sk_core_hold),
    .load_done (sk_load_done),
    .load_err  (sk_load_err)
  );

  always @(negedge clk) begin
    if (we0) begin
      wa_q.push_back(wr_addr0);
      wd_q.push_back(wr_din0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic clear_writes();
    wa_q.delete();
    wd_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    load_req = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    tick(3);

    // Reset state, both boot modes
    check("rst_core_hold", {31'd0, core_hold}, 32'd1);
    check("rst_load_done", {31'd0, load_done}, 32'd0);
    check("rst_load_err",  {31'd0, load_err},  32'd0);
    check("rst_we0",       {31'd0, we0},       32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd0);
    check("rst_wr_addr0",  wr_addr0,           32'h0);
    check("rst_wr_din0",   wr_din0,            32'h0);
    check("skip_core_hold", {31'd0, sk_core_hold}, 32'd0);
    check("skip_load_done", {31'd0, sk_load_done}, 32'd1);
    rst = 1'b0;
    tick(2);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);

    // Two-word load
    clear_writes();
    pulse_req();
    check("hdr0_in_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h93); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    send_byte(8'h02 ^ 8'h13 ^ 8'h93 ^ 8'h10);
`endif
    tick(3);
    check("w2_count", wa_q.size(), 32'd2);
    check("w2_addr0", wa_q[0], 32'h0);
    check("w2_data0", wd_q[0], 32'h00000013);
    check("w2_addr1", wa_q[1], 32'h4);
    check("w2_data1", wd_q[1], 32'h00100093);
    check("w2_done",  {31'd0, load_done}, 32'd1);
    check("w2_hold",  {31'd0, core_hold}, 32'd0);

    // Oversized header -> error
    clear_writes();
    pulse_req();
    check("restart_done_clr", {31'd0, load_done}, 32'd0);
    send_byte(8'h01); send_byte(8'h01);
    tick(3);
    check("big_err",    {31'd0, load_err},  32'd1);
    check("big_hold",   {31'd0, core_hold}, 32'd1);
    check("big_done",   {31'd0, load_done}, 32'd0);
    check("big_nowr",   wa_q.size(),        32'd0);
    check("big_ready",  {31'd0, in_ready},  32'd0);
    pulse_req();
    check("err_restart_clr", {31'd0, load_err}, 32'd0);
    check("err_restart_rdy", {31'd0, in_ready}, 32'd1);

    // Zero-count header
    send_byte(8'h00); send_byte(8'h00);
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    tick(1);
    check("zero_chk_wait", {31'd0, load_done}, 32'd0);
    send_byte(8'h00);
`endif
    tick(1);
    check("zero_done", {31'd0, load_done}, 32'd1);
    check("zero_nowr", wa_q.size(),        32'd0);

    // One word with 7-cycle stream gaps; mid-load load_req is ignored
    clear_writes();
    pulse_req();
    send_byte(8'h01); tick(7);
    send_byte(8'h00); tick(7);
    send_byte(8'hAA); tick(3);
    pulse_req();
    tick(2);
    check("gap_no_we", {31'd0, we0}, 32'd0);
    send_byte(8'hBB); tick(7);
    send_byte(8'hCC); tick(7);
    send_byte(8'hDD);
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    tick(7);
    send_byte(8'h01);
`endif
    tick(3);
    check("gap_count", wa_q.size(), 32'd1);
    check("gap_addr",  wa_q[0],     32'h0);
    check("gap_data",  wd_q[0],     32'hDDCCBBAA);
    check("gap_done",  {31'd0, load_done}, 32'd1);

    // Reset in the middle of a word, then a clean reload
    clear_writes();
    pulse_req();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("midrst_ready", {31'd0, in_ready},  32'd0);
    check("midrst_hold",  {31'd0, core_hold}, 32'd1);
    pulse_req();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    send_byte(8'h45);
`endif
    tick(3);
    check("midrst_count", wa_q.size(), 32'd1);
    check("midrst_addr",  wa_q[0],     32'h0);
    check("midrst_data",  wd_q[0],     32'h11223344);
    check("midrst_done",  {31'd0, load_done}, 32'd1);

`ifdef IMEM_BOOT_LOADER_CHKSUM_EN
    // Checksum good and bad
    clear_writes();
    pulse_req();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    tick(2);
    check("chk_ok_done", {31'd0, load_done}, 32'd1);
    check("chk_ok_wr",   wd_q[0],            32'h04030201);
    clear_writes();
    pulse_req();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h06);
    tick(2);
    check("chk_bad_err",  {31'd0, load_err},  32'd1);
    check("chk_bad_hold", {31'd0, core_hold}, 32'd1);
    check("chk_bad_wr",   wa_q.size(),        32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time sequencer for the instruction memory write port (1R1W SRAM, 32-bit words, byte-addressed).
- Takes a byte stream (valid/ready) from a host link (UART/debug), parses a word-count header, and assembles little-endian 32-bit words.
- Issues one write per word at consecutive word addresses.
- Holds the core in stall until the image is loaded; reports done or error status.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; the header count is checked against it.
- BASE_ADDR, 32'h0, byte address of the first word written.
- BOOT_SKIP, 0, if 1 reset enters DONE directly (core free-runs on a preloaded image).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load_req  input  1  single-cycle request to start or restart a load
- in_data  input  8  stream byte
- in_valid  input  1  stream byte valid
- in_ready  output  1  loader accepts byte this cycle
- wr_addr0  output  32  byte write address to imem (word-aligned, [1:0]=0)
- wr_din0  output  32  write data to imem
- we0  output  1  imem write enable, 1-cycle pulse per word
- core_hold  output  1  stall/hold the core fetch while 1
- load_done  output  1  image loaded successfully (level)
- load_err  output  1  header or checksum error (level)

Behaviour:
- Reset values: in_ready=0, we0=0, wr_addr0=BASE_ADDR, wr_din0=0, load_err=0. With BOOT_SKIP=0: state IDLE, core_hold=1, load_done=0. With BOOT_SKIP=1: state DONE, core_hold=0, load_done=1.
- A byte transfers on a cycle with in_valid & in_ready. in_ready=1 only in HDR0, HDR1, DATA and CHK (macro). in_data is ignored when not transferred.
- IDLE: load_req -> HDR0. Clears the word counter, byte counter and running checksum. Sets wr_addr0=BASE_ADDR.
- HDR0: byte -> count[7:0]. Next state HDR1.
- HDR1: byte -> count[15:8]. Then:
  - count > DEPTH -> ERR.
  - count == 0 -> DONE (or CHK with the macro).
  - otherwise -> DATA.
- DATA: bytes shift into the word little-endian; the first byte goes to bits [7:0]. On the 4th byte, wr_din0 is latched and the state moves to WRITE.
- WRITE: one cycle, we0=1, in_ready=0, with stable wr_addr0/wr_din0. Next cycle: wr_addr0 += 4, word counter += 1. If word counter+1 == count -> DONE (or CHK), else -> DATA.
- Throughput: at most 4 bytes per 5 cycles. Back-to-back bytes are accepted in DATA with no bubble except the WRITE cycle.
- DONE: core_hold=0, load_done=1.
- ERR: core_hold=1, load_err=1, load_done=0.
- load_req in DONE or ERR restarts at HDR0 the next cycle: core_hold=1 and both status flags clear on entry.
- load_req in HDR0, HDR1, DATA, WRITE or CHK is ignored.
- Address counter wraps modulo 2^32. It cannot exceed BASE_ADDR+4*(DEPTH-1) because count<=DEPTH.
- rst mid-load aborts immediately to the reset state. Words already written stay in memory.
- Stream stalls (in_valid=0) of any length cause no timeout and no state change.

Optional Feature:
- Macro IMEM_BOOT_LOADER_CHKSUM_EN.
- When defined:
  - An 8-bit XOR of both header bytes and all data bytes accumulates on each transfer.
  - After the last word (or after the header when count==0), state CHK accepts one more byte.
  - Byte equals the running XOR -> DONE; otherwise -> ERR.
  - Words are already committed on error; core_hold remains 1.
- When undefined: no CHK state, no checksum logic, and the stream ends after the last data byte.

Test Plan:
- Reset with BOOT_SKIP=0 -> core_hold=1, load_done=0, load_err=0, we0=0, in_ready=0. With BOOT_SKIP=1 -> core_hold=0, load_done=1.
- load_req, then stream 02 00, 13 00 00 00, 93 00 10 00 -> two we0 pulses:
  - addr 0x0, data 0x00000013
  - addr 0x4, data 0x00100093
  - Then load_done=1, core_hold=0.
- Header count 0x0101 (257 > DEPTH) -> ERR: load_err=1, core_hold=1, no we0. A following load_req returns to HDR0 with load_err=0.
- Header count 0 -> DONE right after HDR1 (without the macro) with zero writes. Inject in_valid gaps of 7 cycles between bytes of a 1-word load -> same single write, correct data.
- Assert rst after the 2nd data byte, then redo a full 1-word load -> write goes to addr BASE_ADDR, data assembled only from post-reset bytes.
- Macro defined: count 1, data 01 02 03 04, checksum byte 0x05 (01^00^01^02^03^04) -> DONE. Same stream with checksum 0x06 -> ERR, write still issued once.
